// File: rtl/dns_engine_dispatch.sv
// dns_engine_dispatch
//   Round-robin scheduler that hands packets captured by dns_ip_rx to one of
//   N_ENG DNS parse engines. A free engine is picked upward from the last
//   grant, gets a one-cycle start strobe and is held busy until it reports
//   done or its watchdog runs out. Packets whose UDP length is zero or
//   larger than the packet buffer are consumed without a start strobe.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   enable                      allow new dispatches
//   s_dns_valid / s_dns_ready   packet offer / one-cycle consume strobe
//   s_udp_src_ip/dst_ip/length  header of the offered packet
//   m_eng_start                 one-hot start pulse
//   m_eng_abort                 one-cycle abort pulse on watchdog expiry
//   m_eng_done                  engine completion pulses
//   m_eng_busy                  registered busy map
//   m_eng_src_ip/dst_ip/length  header latched for the engine being started
//   stat_dispatch/drop/timeout  saturating event counters

// Per-engine busy flag and watchdog.
//   start   engine is being started this cycle
//   done    engine reports completion
//   busy    engine owns a packet
//   abort   watchdog expired this cycle (suppressed by a same-cycle done)
module dns_eng_wdog #(
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic done,
   output logic busy,
   output logic abort
);
   logic [TO_W-1:0] cnt;

   // cnt counts cycles spent busy, so it reaches TIMEOUT-1 exactly
   // TIMEOUT cycles after the start pulse.
   assign abort = busy && (cnt == TO_W'(TIMEOUT - 1)) && !done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= '0;
      end else if (busy && (done || abort)) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (busy) begin
         cnt  <= cnt + 1'b1;
      end
   end
endmodule

module dns_engine_dispatch #(
   parameter int N_ENG   = 4,
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 50000,
   parameter int MAX_LEN = 512
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             s_dns_valid,
   output logic             s_dns_ready,
   input  logic [31:0]      s_udp_src_ip,
   input  logic [31:0]      s_udp_dst_ip,
   input  logic [15:0]      s_udp_length,
   output logic [N_ENG-1:0] m_eng_start,
   output logic [N_ENG-1:0] m_eng_abort,
   input  logic [N_ENG-1:0] m_eng_done,
   output logic [N_ENG-1:0] m_eng_busy,
   output logic [31:0]      m_eng_src_ip,
   output logic [31:0]      m_eng_dst_ip,
   output logic [15:0]      m_eng_length,
   output logic [31:0]      stat_dispatch,
   output logic [15:0]      stat_drop,
   output logic [15:0]      stat_timeout
);
   localparam int IDX_W = $clog2(N_ENG);

   typedef enum logic [1:0] {IDLE, DISPATCH, DROP} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, sel_q, sel_c;
   logic             found;
   logic             len_ok;
   logic [3:0]       n_abort;
   logic [16:0]      to_sum;

   // ---------------------------------------------------------------
   // Per-engine busy / watchdog
   // ---------------------------------------------------------------
   for (genvar i = 0; i < N_ENG; i++) begin : g_eng
      dns_eng_wdog #(
         .TO_W    (TO_W),
         .TIMEOUT (TIMEOUT)
      ) u_wdog (
         .clk   (clk),
         .rst_n (rst_n),
         .start (m_eng_start[i]),
         .done  (m_eng_done[i]),
         .busy  (m_eng_busy[i]),
         .abort (m_eng_abort[i])
      );
   end

   // ---------------------------------------------------------------
   // Free-engine search, starting just after the last grant
   // ---------------------------------------------------------------
   always_comb begin
      found = 1'b0;
      sel_c = '0;
      for (int k = 1; k <= N_ENG; k++) begin
         if (!found && !m_eng_busy[IDX_W'((int'(ptr_q) + k) % N_ENG)]) begin
            found = 1'b1;
            sel_c = IDX_W'((int'(ptr_q) + k) % N_ENG);
         end
      end
   end

   // 17-bit compare so MAX_LEN values near 2**16 stay exact.
   assign len_ok = (s_udp_length != 16'd0) &&
                   ({1'b0, s_udp_length} <= 17'(MAX_LEN));

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ready/start are decoded from the state register, so an async reset
   // removes them in the same cycle.
   always_comb begin
      state_d     = state_q;
      s_dns_ready = 1'b0;
      m_eng_start = '0;
      case (state_q)
         IDLE: begin
            if (enable && s_dns_valid) begin
               if (!len_ok)    state_d = DROP;
               else if (found) state_d = DISPATCH;
            end
         end
         DISPATCH: begin
            s_dns_ready = 1'b1;
            m_eng_start = N_ENG'(1) << sel_q;
            state_d     = IDLE;
         end
         DROP: begin
            s_dns_ready = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Grant, header latch and statistics
   // ---------------------------------------------------------------
   always_comb begin
      n_abort = '0;
      for (int i = 0; i < N_ENG; i++) n_abort = n_abort + 4'(m_eng_abort[i]);
   end

   assign to_sum = {1'b0, stat_timeout} + 17'(n_abort);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q         <= IDX_W'(N_ENG - 1);
         sel_q         <= '0;
         m_eng_src_ip  <= '0;
         m_eng_dst_ip  <= '0;
         m_eng_length  <= '0;
         stat_dispatch <= '0;
         stat_drop     <= '0;
         stat_timeout  <= '0;
      end else begin
         if (state_q == IDLE && state_d == DISPATCH) begin
            sel_q        <= sel_c;
            m_eng_src_ip <= s_udp_src_ip;
            m_eng_dst_ip <= s_udp_dst_ip;
            m_eng_length <= s_udp_length;
         end
         if (state_q == DISPATCH) begin
            ptr_q <= sel_q;
            if (stat_dispatch != '1) stat_dispatch <= stat_dispatch + 1'b1;
         end
         if (state_q == DROP && stat_drop != '1) stat_drop <= stat_drop + 1'b1;
         if (n_abort != '0) stat_timeout <= to_sum[16] ? '1 : to_sum[15:0];
      end
   end
endmodule
